// File: rtl/rdata_burst_collector.sv
// rdata_burst_collector: gathers one AXI R burst per queued AR ID into a wide line with beat count and error flag
module rdata_burst_collector #(
    parameter int DW     = 32,
    parameter int BEATS  = 4,
    parameter int IDW    = 4,
    parameter int QDEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [IDW-1:0]         rid,
    input  logic [DW-1:0]          rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   req_valid,
    input  logic [IDW-1:0]         req_id,
    output logic                   req_full,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BEATS*DW-1:0]    out_data,
    output logic [IDW-1:0]         out_id,
    output logic [$clog2(BEATS):0] out_beats,
    output logic                   out_err,
    output logic                   id_err_pulse
);
    localparam int AW   = $clog2(QDEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(BEATS) + 1;
    typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;
    state_t                   state_q, state_d;
    logic [IDW-1:0]           fifo_q [QDEPTH];
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]          cnt_q, cnt_d;
    logic [BEATS-1:0][DW-1:0] buf_q, buf_d;
    logic [CW-1:0]            beat_cnt_q, beat_cnt_d;
    logic [IDW-1:0]           out_id_q, out_id_d;
    logic                     sticky_q, sticky_d, id_err_q, id_err_d;
    logic                     push, pop, accept, match, take, room;

    assign req_full     = cnt_q == CNTW'(QDEPTH);
    assign push         = req_valid & ~req_full;
    assign out_valid    = state_q == HOLD;
    assign pop          = out_valid & out_ready;
    assign rready       = state_q == RECV;
    assign accept       = rvalid & rready;
    assign match        = rid == fifo_q[rd_ptr_q];
    assign take         = accept & match;
    assign room         = beat_cnt_q < CW'(BEATS);
    assign out_data     = buf_q;
    assign out_id       = out_id_q;
    assign out_beats    = beat_cnt_q;
    assign out_err      = sticky_q;
    assign id_err_pulse = id_err_q;

    // ID queue storage; only the pointers need reset
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= req_id;
    end

    // next state: queue bookkeeping, line-buffer fill with tail zeroing, error tracking, FSM
    always_comb begin
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        cnt_d      = cnt_q + CNTW'(push) - CNTW'(pop);
        buf_d      = buf_q;
        beat_cnt_d = beat_cnt_q;
        out_id_d   = (take && rlast) ? rid : out_id_q;
        id_err_d   = accept & ~match;
        sticky_d   = sticky_q | (accept & (rresp != 2'b00)) | (accept & ~match) | (take & ~room);
        if (take && room) begin
            for (int i = 0; i < BEATS; i++) begin
                if (CW'(i) == beat_cnt_q) buf_d[i] = rdata;
                else if (rlast && CW'(i) > beat_cnt_q) buf_d[i] = '0;
            end
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (pop) begin
            beat_cnt_d = '0;
            sticky_d   = 1'b0;
        end
        state_d = (state_q == IDLE) ? ((cnt_q != '0) ? RECV : IDLE) :
                  (state_q == RECV) ? ((take && rlast) ? HOLD : RECV) :
                  (pop ? ((cnt_d != '0) ? RECV : IDLE) : HOLD);
    end

    // state registers with synchronous reset that also aborts any burst in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            beat_cnt_q <= '0;
            out_id_q   <= '0;
            sticky_q   <= 1'b0;
            id_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            beat_cnt_q <= beat_cnt_d;
            out_id_q   <= out_id_d;
            sticky_q   <= sticky_d;
            id_err_q   <= id_err_d;
        end
    end
endmodule

// File: tb/tb_rdata_burst_collector.sv
// tb_rdata_burst_collector: scoreboarded random and directed bench for the R-burst collector
module tb_rdata_burst_collector;
    localparam int DW = 32, BEATS = 4, IDW = 4, QDEPTH = 4;
    localparam int LW = BEATS * DW;
    localparam int CW = $clog2(BEATS) + 1;
    typedef struct {
        logic [LW-1:0]  data;
        logic [IDW-1:0] id;
        int             beats;
        logic           err;
    } exp_t;
    logic           clk = 0, rst = 1, rvalid = 0, rlast = 0, req_valid = 0, out_ready = 0;
    logic [IDW-1:0] rid = '0, req_id = '0;
    logic [DW-1:0]  rdata = '0;
    logic [1:0]     rresp = '0;
    logic           rready, req_full, out_valid, out_err, id_err_pulse;
    logic [LW-1:0]  out_data;
    logic [IDW-1:0] out_id;
    logic [CW-1:0]  out_beats;
    exp_t           exp_q[$];
    logic [IDW-1:0] idq[$];
    int             checks = 0, errors = 0, exp_pulses = 0, seen_pulses = 0, rmode = 1;

    rdata_burst_collector #(.DW(DW), .BEATS(BEATS), .IDW(IDW), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast), .req_valid(req_valid), .req_id(req_id), .req_full(req_full),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .out_beats(out_beats), .out_err(out_err), .id_err_pulse(id_err_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rmode == 0) out_ready = $urandom_range(0, 3) != 0;
        else out_ready = rmode == 1;
    endtask

    task automatic push_id(input logic [IDW-1:0] i);
        req_valid = 1;
        req_id = i;
        step();
        req_valid = 0;
    endtask

    task automatic send_beat(input logic [IDW-1:0] i, input logic [DW-1:0] d, input logic [1:0] r, input logic l);
        int t = 0;
        rvalid = 1; rid = i; rdata = d; rresp = r; rlast = l;
        while (!rready && t < 200) begin
            step();
            t++;
        end
        if (!rready) chk("rready_timeout", LW'(rready), LW'(1));
        else step();
        rvalid = 0;
        rlast = 0;
    endtask

    // reference: slots hold matching beats in order up to BEATS, rest zero; error if any bad resp, wrong ID or overflow
    task automatic burst(input logic [IDW-1:0] id, input int n, input logic [7:0] mis, input logic [7:0] errm, input logic [DW-1:0] base);
        exp_t e;
        e.data = '0;
        e.id = id;
        e.beats = n < BEATS ? n : BEATS;
        e.err = n > BEATS;
        for (int k = 0; k < n; k++) begin
            if (k < BEATS) e.data[k*DW +: DW] = base + DW'(k);
            e.err = e.err | mis[k] | errm[k];
        end
        exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            if (mis[k]) begin
                send_beat(id + IDW'($urandom_range(1, 15)), $urandom, 2'b00, 1'b0);
                exp_pulses++;
                chk("id_err_pulse", LW'(id_err_pulse), LW'(1));
            end
            send_beat(id, base + DW'(k), errm[k] ? 2'b10 : 2'b00, k == n - 1);
        end
        chk("out_valid_latency", LW'(out_valid), LW'(1));
        chk("rready_in_hold", LW'(rready), LW'(0));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            step();
            t++;
        end
        chk("drain", LW'(exp_q.size()), LW'(0));
    endtask

    // monitor: ID-queue occupancy model, pulse counting and scoreboard pop on each output handshake
    initial forever begin
        logic can_push;
        exp_t e;
        @(negedge clk);
        if (rst) begin
            idq.delete();
        end else begin
            chk("req_full", LW'(req_full), LW'(idq.size() == QDEPTH));
            if (id_err_pulse) seen_pulses++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out_valid", LW'(out_valid), LW'(0));
                else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_id", LW'(out_id), LW'(e.id));
                    chk("out_beats", LW'(out_beats), LW'(e.beats));
                    chk("out_err", LW'(out_err), LW'(e.err));
                end
            end
            can_push = req_valid && idq.size() < QDEPTH;
            if (out_valid && out_ready && idq.size() != 0) void'(idq.pop_front());
            if (can_push) idq.push_back(req_id);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        rst = 0;
        chk("rst_rready", LW'(rready), LW'(0));
        chk("rst_out_valid", LW'(out_valid), LW'(0));
        chk("rst_out_err", LW'(out_err), LW'(0));
        chk("rst_id_err", LW'(id_err_pulse), LW'(0));
        chk("rst_req_full", LW'(req_full), LW'(0));
        chk("rst_out_data", out_data, LW'(0));
        chk("rst_out_id", LW'(out_id), LW'(0));
        chk("rst_out_beats", LW'(out_beats), LW'(0));
        rmode = 1;
        push_id(3);
        burst(3, 4, 8'h00, 8'h00, 32'hA0);
        push_id(7);
        burst(7, 2, 8'h00, 8'h00, 32'hB0);
        push_id(5);
        burst(5, 4, 8'h02, 8'h00, 32'hC0);
        push_id(13);
        burst(13, 6, 8'h00, 8'h00, 32'hD0);
        push_id(14);
        burst(14, 3, 8'h00, 8'h04, 32'hE0);
        drain();
        rmode = 2;
        push_id(9);
        burst(9, 3, 8'h00, 8'h00, 32'h90);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", LW'(out_valid), LW'(1));
            chk("stall_rready", LW'(rready), LW'(0));
            chk("stall_data", out_data, exp_q[0].data);
            chk("stall_beats", LW'(out_beats), LW'(exp_q[0].beats));
            chk("stall_id", LW'(out_id), LW'(exp_q[0].id));
        end
        push_id(10);
        rmode = 1;
        burst(10, 4, 8'h00, 8'h00, 32'h100);
        drain();
        rmode = 2;
        for (int i = 1; i <= QDEPTH; i++) push_id(IDW'(i));
        chk("full_after_fill", LW'(req_full), LW'(1));
        push_id(15);
        chk("full_after_extra", LW'(req_full), LW'(1));
        rmode = 1;
        burst(1, 2, 8'h00, 8'h00, 32'h10);
        burst(2, 2, 8'h00, 8'h00, 32'h20);
        drain();
        rmode = 2;
        burst(3, 2, 8'h00, 8'h00, 32'h30);
        rmode = 1;
        out_ready = 1;
        req_valid = 1;
        req_id = 6;
        step();
        req_valid = 0;
        chk("pushpop_not_full", LW'(req_full), LW'(0));
        push_id(7);
        chk("pushpop_three", LW'(req_full), LW'(0));
        push_id(8);
        chk("pushpop_full", LW'(req_full), LW'(1));
        burst(4, 1, 8'h00, 8'h00, 32'h40);
        burst(6, 3, 8'h00, 8'h00, 32'h60);
        burst(7, 4, 8'h00, 8'h00, 32'h70);
        burst(8, 2, 8'h00, 8'h00, 32'h80);
        drain();
        repeat (3) step();
        chk("queue_drained", LW'(rready), LW'(0));
        rmode = 0;
        for (int it = 0; it < 30; it++) begin
            logic [IDW-1:0] id;
            int n;
            logic [7:0] mis, errm;
            id = IDW'($urandom_range(0, 15));
            n = $urandom_range(1, BEATS + 2);
            mis = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 63)) : 8'h00;
            errm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 63)) : 8'h00;
            push_id(id);
            burst(id, n, mis, errm, $urandom);
        end
        rmode = 1;
        drain();
        push_id(11);
        send_beat(11, 32'h1111, 2'b00, 1'b0);
        send_beat(11, 32'h2222, 2'b00, 1'b0);
        rst = 1;
        step();
        chk("abort_rready", LW'(rready), LW'(0));
        chk("abort_req_full", LW'(req_full), LW'(0));
        chk("abort_out_valid", LW'(out_valid), LW'(0));
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_out", LW'(out_valid), LW'(0));
        end
        chk("abort_queue_empty", LW'(rready), LW'(0));
        push_id(12);
        burst(12, 2, 8'h00, 8'h00, 32'hF0);
        drain();
        chk("id_err_pulse_count", LW'(seen_pulses), LW'(exp_pulses));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
